// File: rtl/bf16_cmp_pkg.sv
// Shared BF16 compare types, op encoding and classification helpers.
package bf16_cmp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  typedef enum logic [1:0] {
    OP_MAX = 2'd0,
    OP_MIN = 2'd1,
    OP_LT  = 2'd2,
    OP_EQ  = 2'd3
  } cmp_op_e;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [7:0]  EXP_ALL1  = 8'hFF;

  function automatic logic is_nan(input bf16_t x);
    return (x.exp == EXP_ALL1) && (x.man != 7'd0);
  endfunction

  function automatic logic is_zero(input bf16_t x);
    return (x.exp == 8'd0) && (x.man == 7'd0);
  endfunction

endpackage

// File: rtl/bf16_lane_cmp.sv
// One BF16 lane: classification/ordering of the incoming operands, and result
// select from the stage-1 registered operands and flags.
module bf16_lane_cmp
  import bf16_cmp_pkg::*;
(
  input  bf16_t       a,
  input  bf16_t       b,
  output logic        a_nan,
  output logic        b_nan,
  output logic        a_lt_b,
  output logic        a_eq_b,
  input  bf16_t       a_p1,
  input  bf16_t       b_p1,
  input  cmp_op_e     op_p1,
  input  logic        a_nan_p1,
  input  logic        b_nan_p1,
  input  logic        a_lt_b_p1,
  input  logic        a_eq_b_p1,
  output logic [15:0] res
);

  logic both_zero;
  logic b_lt_a;

  always_comb begin
    a_nan     = is_nan(a);
    b_nan     = is_nan(b);
    both_zero = is_zero(a) && is_zero(b);
    a_eq_b    = !a_nan && !b_nan && (both_zero || (a == b));
    // Negative operands order by inverted magnitude.
    if (a_nan || b_nan || both_zero) a_lt_b = 1'b0;
    else if (a.sign != b.sign)       a_lt_b = a.sign;
    else if (a.sign)                 a_lt_b = {a.exp, a.man} > {b.exp, b.man};
    else                             a_lt_b = {a.exp, a.man} < {b.exp, b.man};
  end

  // Ordering is total once NaNs are excluded, so b<a is the remaining case.
  assign b_lt_a = !a_lt_b_p1 && !a_eq_b_p1;

  always_comb begin
    res = a_p1;
    case (op_p1)
      OP_MAX: begin
        if (a_nan_p1 && b_nan_p1) res = BF16_QNAN;
        else if (a_nan_p1)        res = b_p1;
        else if (b_nan_p1)        res = a_p1;
        else if (a_lt_b_p1)       res = b_p1;
        else                      res = a_p1;
      end
      OP_MIN: begin
        if (a_nan_p1 && b_nan_p1) res = BF16_QNAN;
        else if (a_nan_p1)        res = b_p1;
        else if (b_nan_p1)        res = a_p1;
        else if (b_lt_a)          res = b_p1;
        else                      res = a_p1;
      end
      OP_LT:   res = {15'd0, a_lt_b_p1};
      OP_EQ:   res = {15'd0, a_eq_b_p1};
      default: res = a_p1;
    endcase
  end

endmodule

// File: rtl/bf16_vec_cmp_pipe.sv
// N-lane BF16 MAX/MIN/LT/EQ engine, 2-stage stallable valid/ready pipeline.
// Optional per-lane NaN flag output when BF16_CMP_NAN_FLAG_EN is defined.
module bf16_vec_cmp_pipe
  import bf16_cmp_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic [16*N-1:0]   a1,
  input  logic [16*N-1:0]   b1,
  input  logic [1:0]        op,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [16*N-1:0]   c1,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef BF16_CMP_NAN_FLAG_EN
  output logic [N-1:0]      nan_flag,
`endif
  output logic [CNT_W-1:0]  txn_cnt
);

  logic              vld_p1, vld_p2, adv1, adv2;
  logic [16*N-1:0]   a_p1, b_p1, res_p1, c_p2;
  cmp_op_e           op_p1;
  logic [N-1:0]      a_nan_p0, b_nan_p0, lt_p0, eq_p0;
  logic [N-1:0]      a_nan_p1, b_nan_p1, lt_p1, eq_p1;

  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  for (genvar i = 0; i < N; i++) begin : g_lane
    bf16_lane_cmp u_lane (
      .a         (a1[16*i +: 16]),
      .b         (b1[16*i +: 16]),
      .a_nan     (a_nan_p0[i]),
      .b_nan     (b_nan_p0[i]),
      .a_lt_b    (lt_p0[i]),
      .a_eq_b    (eq_p0[i]),
      .a_p1      (a_p1[16*i +: 16]),
      .b_p1      (b_p1[16*i +: 16]),
      .op_p1     (op_p1),
      .a_nan_p1  (a_nan_p1[i]),
      .b_nan_p1  (b_nan_p1[i]),
      .a_lt_b_p1 (lt_p1[i]),
      .a_eq_b_p1 (eq_p1[i]),
      .res       (res_p1[16*i +: 16])
    );
  end

  // Stage 1: operands, op and per-lane classification
  always_ff @(posedge clk1) begin
    if (rst1)      vld_p1 <= 1'b0;
    else if (adv1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk1) begin
    if (adv1 && in_valid) begin
      a_p1     <= a1;
      b_p1     <= b1;
      op_p1    <= cmp_op_e'(op);
      a_nan_p1 <= a_nan_p0;
      b_nan_p1 <= b_nan_p0;
      lt_p1    <= lt_p0;
      eq_p1    <= eq_p0;
    end
  end

  // Stage 2: selected result, held while downstream stalls
  always_ff @(posedge clk1) begin
    if (rst1) begin
      vld_p2 <= 1'b0;
      c_p2   <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) c_p2 <= res_p1;
    end
  end

`ifdef BF16_CMP_NAN_FLAG_EN
  logic [N-1:0] nan_p2;

  always_ff @(posedge clk1) begin
    if (rst1)                 nan_p2 <= '0;
    else if (adv2 && vld_p1)  nan_p2 <= a_nan_p1 | b_nan_p1;
  end

  assign nan_flag = nan_p2;
`endif

  always_ff @(posedge clk1) begin
    if (rst1)                        txn_cnt <= '0;
    else if (vld_p2 && out_ready)    txn_cnt <= txn_cnt + CNT_W'(1);
  end

  assign c1        = c_p2;
  assign out_valid = vld_p2;

endmodule

// File: tb/tb_bf16_vec_cmp_pipe.sv
// Bench for bf16_vec_cmp_pipe: directed cases plus random traffic against a
// real-valued reference model and an in-order scoreboard.
module tb_bf16_vec_cmp_pipe;

  localparam int N     = 2;
  localparam int CNT_W = 4;

  logic              clk1 = 1'b0;
  logic              rst1 = 1'b1;
  logic [16*N-1:0]   a1 = '0, b1 = '0;
  logic [1:0]        op = 2'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [16*N-1:0]   c1;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  txn_cnt;
`ifdef BF16_CMP_NAN_FLAG_EN
  logic [N-1:0]      nan_flag;
`endif

  bf16_vec_cmp_pipe #(.N(N), .CNT_W(CNT_W)) dut (
    .clk1      (clk1),
    .rst1      (rst1),
    .a1        (a1),
    .b1        (b1),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c1        (c1),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BF16_CMP_NAN_FLAG_EN
    .nan_flag  (nan_flag),
`endif
    .txn_cnt   (txn_cnt)
  );

  always #5 clk1 = ~clk1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: decode BF16 to a real and compare numerically.
  function automatic real bf_val(input logic [15:0] x);
    real m;
    int  e;
    e = int'(x[14:7]);
    if (e == 0)        m = real'(x[6:0]) * (2.0 ** (-133));
    else if (e == 255) m = 1.0e300;
    else               m = real'(128 + int'(x[6:0])) * (2.0 ** (e - 134));
    return x[15] ? -m : m;
  endfunction

  function automatic logic [16:0] ref_lane(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] o);
    logic        an, bn;
    logic [15:0] r;
    real         va, vb;
    an = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    bn = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    va = bf_val(a);
    vb = bf_val(b);
    case (o)
      2'd0:    r = (an && bn) ? 16'h7FC0 : an ? b : bn ? a : (va < vb) ? b : a;
      2'd1:    r = (an && bn) ? 16'h7FC0 : an ? b : bn ? a : (vb < va) ? b : a;
      2'd2:    r = {15'd0, !an && !bn && (va < vb)};
      default: r = {15'd0, !an && !bn && (va == vb)};
    endcase
    return {an | bn, r};
  endfunction

  typedef struct {
    logic [16*N-1:0] c;
    logic [N-1:0]    nf;
    int              t;
  } exp_t;

  exp_t            q[$];
  int              cyc    = 0;
  bit              mon_en = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  bit              hold_v = 0;
  logic [16*N-1:0] hold_c;

  always @(negedge clk1) begin
    if (mon_en) begin
      exp_t        e;
      logic [16:0] lr;
      cyc++;
      chk("txn_cnt", txn_cnt, exp_cnt);
      if (rst1) begin
        q.delete();
        exp_cnt = '0;
        hold_v  = 0;
      end else begin
        chk("out_valid", out_valid, (q.size() > 0) && (cyc - q[0].t >= 2));
        chk("in_ready", in_ready, (q.size() < 2) || out_ready);
        if (hold_v && out_valid) chk("hold_c1", c1, hold_c);
        hold_v = out_valid && !out_ready;
        hold_c = c1;
        if (out_valid && out_ready && q.size() > 0) begin
          chk("c1", c1, q[0].c);
`ifdef BF16_CMP_NAN_FLAG_EN
          chk("nan_flag", nan_flag, q[0].nf);
`endif
          void'(q.pop_front());
          exp_cnt = exp_cnt + CNT_W'(1);
        end
        if (in_valid && in_ready) begin
          for (int l = 0; l < N; l++) begin
            lr = ref_lane(a1[16*l +: 16], b1[16*l +: 16], op);
            e.c[16*l +: 16] = lr[15:0];
            e.nf[l]         = lr[16];
          end
          e.t = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic send_beat(input logic [16*N-1:0] a, input logic [16*N-1:0] b,
                           input logic [1:0] o);
    bit done = 0;
    a1 = a; b1 = b; op = o; in_valid = 1'b1;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk1);
      done = in_ready;
      @(posedge clk1);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", done, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 200 && q.size() != 0; k++) wait_cycles(1);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_directed(input string tag, input logic [16*N-1:0] a,
                             input logic [16*N-1:0] b, input logic [1:0] o,
                             input logic [16*N-1:0] expc, input logic [N-1:0] expnf);
    out_ready = 1'b1;
    send_beat(a, b, o);
    @(negedge clk1);
    chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk1);
    chk({tag, "_lat2"}, out_valid, 1);
    chk({tag, "_c1"}, c1, expc);
`ifdef BF16_CMP_NAN_FLAG_EN
    chk({tag, "_nan"}, nan_flag, expnf);
`else
    if (expnf === 'x) $display("unexpected X nan expectation in %s", tag);
`endif
    @(negedge clk1);
    chk({tag, "_once"}, out_valid, 0);
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [15:0] rand_bf();
    case ($urandom_range(0, 3))
      0: case ($urandom_range(0, 7))
           0: return 16'h0000;
           1: return 16'h8000;
           2: return 16'h7F80;
           3: return 16'hFF80;
           4: return 16'h7FC0;
           5: return 16'h0001;
           6: return 16'h3F80;
           default: return 16'hFF81;
         endcase
      1: return {1'($urandom), 8'h7F, 7'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  bit done_tx = 0;

  initial begin
    logic [16*N-1:0] ra, rb;
    logic [CNT_W-1:0] base;

    repeat (2) @(posedge clk1);
    #1;
    mon_en = 1;
    @(posedge clk1);
    #1;
    rst1 = 1'b0;
    @(negedge clk1);
    chk("rst_c1", c1, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk1);
    #1;

    do_directed("max", {16'h3F80, 16'hBF80}, {16'h4000, 16'h0000}, 2'd0,
                {16'h4000, 16'h0000}, 2'b00);
    chk("max_txn", txn_cnt, 1);
    do_directed("min_nan", {16'h7FC1, 16'h7FC1}, {16'h3F80, 16'h7F81}, 2'd1,
                {16'h3F80, 16'h7FC0}, 2'b11);
    do_directed("eq_zero", {16'h0000, 16'h0000}, {16'h8000, 16'h8000}, 2'd3,
                {16'h0001, 16'h0001}, 2'b00);
    do_directed("lt", {16'hBF80, 16'h7FC0}, {16'h0000, 16'h3F80}, 2'd2,
                {16'h0001, 16'h0000}, 2'b01);

    // Back-pressure: 5 beats streamed while the output is stalled.
    base = txn_cnt;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++)
        send_beat({16'h3F80 + 16'(i), 16'h4000 - 16'(i)},
                  {16'h3F80, 16'h4000}, 2'(i));
      begin
        repeat (3) @(negedge clk1);
        chk("bp_in_ready", in_ready, 0);
      end
      begin
        wait_cycles(5);
        out_ready = 1'b1;
      end
    join
    drain();
    wait_cycles(1);
    chk("bp_txn", txn_cnt, base + CNT_W'(5));

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send_beat({16'h1234, 16'h4321}, {16'h2222, 16'h3333}, 2'd0);
    send_beat({16'h5555, 16'h6666}, {16'h7777, 16'h0101}, 2'd1);
    rst1 = 1'b1;
    wait_cycles(1);
    rst1 = 1'b0;
    @(negedge clk1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_txn", txn_cnt, 0);
    @(posedge clk1);
    #1;
    do_directed("post_rst", {16'hC000, 16'h0080}, {16'hBF80, 16'h0001}, 2'd0,
                {16'hBF80, 16'h0080}, 2'b00);

    // Random traffic with random output stalls.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          for (int l = 0; l < N; l++) begin
            ra[16*l +: 16] = rand_bf();
            case ($urandom_range(0, 5))
              0:       rb[16*l +: 16] = ra[16*l +: 16];
              1:       rb[16*l +: 16] = ra[16*l +: 16] ^ 16'h8000;
              default: rb[16*l +: 16] = rand_bf();
            endcase
          end
          send_beat(ra, rb, 2'($urandom));
          if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
        end
        done_tx = 1;
      end
      begin
        while (!done_tx) begin
          out_ready = ($urandom_range(0, 2) != 0);
          wait_cycles(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter wrap: 17 transfers on a 4-bit counter.
    rst1 = 1'b1;
    wait_cycles(1);
    rst1 = 1'b0;
    for (int i = 0; i < 17; i++)
      send_beat({16'(i), 16'h8000}, {16'h0000, 16'(i)}, 2'd2);
    drain();
    wait_cycles(1);
    chk("wrap_txn", txn_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
